// File: rtl/gmac_cfg_seq.sv
// Table-driven GMAC/PHY register-init sequencer: fetches command words from a
// synchronous ROM and runs them over an Avalon-style wait-request register port.
module gmac_cfg_seq #(
  parameter int unsigned AW       = 8,
  parameter int unsigned DW       = 32,
  parameter int unsigned IW       = 5,
  parameter int unsigned DELAY_W  = 26,
  parameter int unsigned POLL_MAX = 1024,
  localparam int unsigned CW      = 3 + AW + DW
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [IW-1:0] o_cmd_idx,
  input  logic [CW-1:0] i_cmd,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_wr_data,
  output logic          o_wr,
  output logic          o_rd,
  input  logic [DW-1:0] i_rd_data,
  input  logic          i_wtrq,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic [IW-1:0] o_err_idx,
  output logic [3:0]    o_state
);

  localparam int unsigned PCW = $clog2(POLL_MAX + 1);

  localparam logic [3:0] S_DELAY   = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_RD      = 4'd3;
  localparam logic [3:0] S_WR      = 4'd4;
  localparam logic [3:0] S_POLL_RD = 4'd5;
  localparam logic [3:0] S_WAIT    = 4'd6;
  localparam logic [3:0] S_DONE    = 4'd7;
  localparam logic [3:0] S_ERR     = 4'd8;

  localparam logic [2:0] OP_END      = 3'd0;
  localparam logic [2:0] OP_WR       = 3'd1;
  localparam logic [2:0] OP_OR       = 3'd2;
  localparam logic [2:0] OP_ANDN     = 3'd3;
  localparam logic [2:0] OP_POLL_CLR = 3'd4;
  localparam logic [2:0] OP_POLL_SET = 3'd5;
  localparam logic [2:0] OP_WAIT     = 3'd6;

  // Counter leaves DELAY after 2^DELAY_W-1 cycles (values 0 .. all-ones minus one).
  localparam logic [DELAY_W-1:0] DLY_LAST  = {{(DELAY_W-1){1'b1}}, 1'b0};
  localparam logic [PCW-1:0]     POLL_LAST = PCW'(POLL_MAX);

  logic [3:0]         state_q, state_d;
  logic [DELAY_W-1:0] delay_q, delay_d;
  logic [2:0]         op_q, op_d;
  logic [DW-1:0]      arg_q, arg_d;
  logic [DW-1:0]      r_reg, r_reg_d;
  logic [PCW-1:0]     poll_q, poll_d;
  logic [DW-1:0]      wait_q, wait_d;
  logic [IW-1:0]      idx_d, err_idx_d;
  logic [AW-1:0]      addr_d;
  logic [DW-1:0]      wr_data_d;
  logic               wr_d, rd_d, busy_d, done_d, err_d;

  logic [2:0]    op_c;
  logic [AW-1:0] addr_c;
  logic [DW-1:0] arg_c;
  logic          rd_ok_c, wr_ok_c, poll_met_c, cmd_done_c, go_done_c;

  assign o_state = state_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    delay_d    = delay_q;
    op_d       = op_q;
    arg_d      = arg_q;
    r_reg_d    = r_reg;
    poll_d     = poll_q;
    wait_d     = wait_q;
    idx_d      = o_cmd_idx;
    err_idx_d  = o_err_idx;
    addr_d     = o_addr;
    wr_data_d  = o_wr_data;
    wr_d       = o_wr;
    rd_d       = o_rd;
    busy_d     = o_busy;
    done_d     = o_done;
    err_d      = o_err;
    cmd_done_c = 1'b0;
    go_done_c  = 1'b0;

    op_c    = i_cmd[CW-1 -: 3];
    addr_c  = i_cmd[DW +: AW];
    arg_c   = i_cmd[DW-1:0];
    rd_ok_c = o_rd && !i_wtrq;
    wr_ok_c = o_wr && !i_wtrq;
    poll_met_c = (op_q == OP_POLL_CLR) ? ((r_reg & arg_q) == '0)
                                       : ((r_reg & arg_q) == arg_q);

    case (state_q)
      S_DELAY: begin
        delay_d = delay_q + 1'b1;
        if (delay_q == DLY_LAST) begin
          state_d = S_FETCH;
          idx_d   = '0;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        op_d   = op_c;
        arg_d  = arg_c;
        addr_d = addr_c;
        case (op_c)
          OP_END: go_done_c = 1'b1;
          OP_WR: begin
            wr_data_d = arg_c;
            wr_d      = 1'b1;
            state_d   = S_WR;
          end
          OP_OR, OP_ANDN: begin
            rd_d    = 1'b1;
            state_d = S_RD;
          end
          OP_POLL_CLR, OP_POLL_SET: begin
            rd_d    = 1'b1;
            poll_d  = '0;
            state_d = S_POLL_RD;
          end
          OP_WAIT: begin
            if (arg_c == '0) begin
              cmd_done_c = 1'b1;
            end else begin
              wait_d  = arg_c - 1'b1;
              state_d = S_WAIT;
            end
          end
          default: begin
            state_d   = S_ERR;
            err_d     = 1'b1;
            busy_d    = 1'b0;
            err_idx_d = o_cmd_idx;
          end
        endcase
      end
      S_RD: begin
        // Read-modify-write: write phase follows the read with no idle cycle
        if (rd_ok_c) begin
          r_reg_d   = i_rd_data;
          rd_d      = 1'b0;
          wr_d      = 1'b1;
          wr_data_d = (op_q == OP_OR) ? (i_rd_data | arg_q) : (i_rd_data & ~arg_q);
          state_d   = S_WR;
        end
      end
      S_WR: begin
        if (wr_ok_c) begin
          wr_d       = 1'b0;
          cmd_done_c = 1'b1;
        end
      end
      S_POLL_RD: begin
        // Idle cycle between strobes evaluates the captured read data
        if (o_rd) begin
          if (rd_ok_c) begin
            rd_d    = 1'b0;
            r_reg_d = i_rd_data;
            poll_d  = poll_q + 1'b1;
          end
        end else if (poll_met_c) begin
          cmd_done_c = 1'b1;
        end else if (poll_q == POLL_LAST) begin
          state_d   = S_ERR;
          err_d     = 1'b1;
          busy_d    = 1'b0;
          err_idx_d = o_cmd_idx;
        end else begin
          rd_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (wait_q == '0) cmd_done_c = 1'b1;
        else              wait_d     = wait_q - 1'b1;
      end
      S_DONE, S_ERR: begin
        if (i_start) begin
          state_d   = S_FETCH;
          idx_d     = '0;
          done_d    = 1'b0;
          err_d     = 1'b0;
          err_idx_d = '0;
          busy_d    = 1'b1;
        end
      end
      default: state_d = S_DELAY;
    endcase

    // The last table entry finishing without END ends the sequence
    if (cmd_done_c) begin
      if (o_cmd_idx == '1) begin
        go_done_c = 1'b1;
      end else begin
        idx_d   = o_cmd_idx + 1'b1;
        state_d = S_FETCH;
      end
    end
    if (go_done_c) begin
      state_d = S_DONE;
      done_d  = 1'b1;
      busy_d  = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_DELAY;
      delay_q   <= '0;
      op_q      <= '0;
      arg_q     <= '0;
      r_reg     <= '0;
      poll_q    <= '0;
      wait_q    <= '0;
      o_cmd_idx <= '0;
      o_err_idx <= '0;
      o_addr    <= '0;
      o_wr_data <= '0;
      o_wr      <= 1'b0;
      o_rd      <= 1'b0;
      o_busy    <= 1'b1;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      state_q   <= state_d;
      delay_q   <= delay_d;
      op_q      <= op_d;
      arg_q     <= arg_d;
      r_reg     <= r_reg_d;
      poll_q    <= poll_d;
      wait_q    <= wait_d;
      o_cmd_idx <= idx_d;
      o_err_idx <= err_idx_d;
      o_addr    <= addr_d;
      o_wr_data <= wr_data_d;
      o_wr      <= wr_d;
      o_rd      <= rd_d;
      o_busy    <= busy_d;
      o_done    <= done_d;
      o_err     <= err_d;
    end
  end

endmodule

// File: tb/tb_gmac_cfg_seq.sv
// Directed bench for gmac_cfg_seq: ROM and wait-request slave models plus a transfer log.
module tb_gmac_cfg_seq;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 3;
  localparam int unsigned CW = 3 + AW + DW;

  logic          clk;
  logic          rst_n, rst2_n;
  logic [IW-1:0] o_cmd_idx, o_err_idx;
  logic [CW-1:0] rom_q;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_wr_data, i_rd_data, rd_val, rd_first;
  logic          o_wr, o_rd, i_wtrq, i_start, o_busy, o_done, o_err;
  logic [3:0]    o_state;
  logic [CW-1:0] rom [8];

  logic [1:0]    idx2, err_idx2;
  logic [CW-1:0] rom2_q;
  logic [AW-1:0] addr2;
  logic [DW-1:0] wr_data2, rd_data2;
  logic          wr2, rd2, wtrq2, start2, busy2, done2, err2;
  logic [3:0]    state2;

  int n_tests, n_fail;
  int wait_n, hold_cnt, rd_cnt, rd_base, rd_switch;
  int rd_cycles, wr_cycles, both_hi, addr90_cycles;
  int wr2_cnt;
  logic [AW-1:0] last2_addr;
  logic [DW-1:0] last2_data;
  logic          log_wr [$];
  logic [AW-1:0] log_addr [$];
  logic [DW-1:0] log_data [$];
  int lb, rcb, wcb, acb;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  gmac_cfg_seq #(.AW(AW), .DW(DW), .IW(IW), .DELAY_W(4), .POLL_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n), .o_cmd_idx(o_cmd_idx), .i_cmd(rom_q),
    .o_addr(o_addr), .o_wr_data(o_wr_data), .o_wr(o_wr), .o_rd(o_rd),
    .i_rd_data(i_rd_data), .i_wtrq(i_wtrq), .i_start(i_start),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_err_idx(o_err_idx),
    .o_state(o_state)
  );

  gmac_cfg_seq #(.AW(AW), .DW(DW), .IW(2), .DELAY_W(2), .POLL_MAX(4)) dut2 (
    .clk(clk), .rst_n(rst2_n), .o_cmd_idx(idx2), .i_cmd(rom2_q),
    .o_addr(addr2), .o_wr_data(wr_data2), .o_wr(wr2), .o_rd(rd2),
    .i_rd_data(rd_data2), .i_wtrq(wtrq2), .i_start(start2),
    .o_busy(busy2), .o_done(done2), .o_err(err2), .o_err_idx(err_idx2),
    .o_state(state2)
  );

  function automatic logic [CW-1:0] mk(input logic [2:0] op, input logic [AW-1:0] a,
                                       input logic [DW-1:0] d);
    return {op, a, d};
  endfunction

  assign i_wtrq    = (o_rd || o_wr) && (hold_cnt < wait_n);
  assign i_rd_data = ((rd_cnt - rd_base) < rd_switch) ? rd_first : rd_val;
  assign wtrq2     = 1'b0;
  assign rd_data2  = '0;
  assign start2    = 1'b0;

  // Synchronous ROMs and bus slave / monitor
  always @(posedge clk) begin
    rom_q  <= rom[o_cmd_idx];
    rom2_q <= mk(3'd1, AW'(idx2), DW'(idx2) + 32'd1);
    if ((o_rd || o_wr) && i_wtrq) hold_cnt <= hold_cnt + 1;
    else                          hold_cnt <= 0;
    if ((o_rd || o_wr) && !i_wtrq) begin
      log_wr.push_back(o_wr);
      log_addr.push_back(o_addr);
      log_data.push_back(o_wr ? o_wr_data : i_rd_data);
      if (o_rd) rd_cnt <= rd_cnt + 1;
    end
    if (o_rd) rd_cycles <= rd_cycles + 1;
    if (o_wr) wr_cycles <= wr_cycles + 1;
    if (o_rd && o_wr) both_hi <= both_hi + 1;
    if ((o_rd || o_wr) && o_addr == 8'h90) addr90_cycles <= addr90_cycles + 1;
    if (wr2) begin
      wr2_cnt    <= wr2_cnt + 1;
      last2_addr <= addr2;
      last2_data <= wr_data2;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_log(input string tag, input int i, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (lb + i < log_addr.size()) begin
      check_eq({tag, "_dir"}, 64'(log_wr[lb + i]), 64'(w));
      check_eq({tag, "_addr"}, 64'(log_addr[lb + i]), 64'(a));
      check_eq({tag, "_data"}, 64'(log_data[lb + i]), 64'(d));
    end else begin
      check_eq({tag, "_present"}, 64'(log_addr.size() - lb), 64'(i + 1));
    end
  endtask

  task automatic snap();
    lb      = log_addr.size();
    rcb     = rd_cycles;
    wcb     = wr_cycles;
    acb     = addr90_cycles;
    rd_base = rd_cnt;
  endtask

  task automatic start_seq();
    snap();
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (!(o_done || o_err) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("seq_end", 64'(o_done | o_err), 64'd1);
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    wait_n = 0; hold_cnt = 0; rd_cnt = 0; rd_base = 0; rd_switch = 0;
    rd_cycles = 0; wr_cycles = 0; both_hi = 0; addr90_cycles = 0; wr2_cnt = 0;
    last2_addr = '0; last2_data = '0;
    rd_val = '0; rd_first = '0;
    rst_n = 1'b0; rst2_n = 1'b0; i_start = 1'b0;
    lb = 0; rcb = 0; wcb = 0; acb = 0;
    rom[0] = mk(3'd1, 8'h02, 32'h0000_0008);
    rom[1] = mk(3'd1, 8'h03, 32'hEC36_2200);
    rom[2] = mk(3'd1, 8'h04, 32'h0000_0104);
    rom[3] = mk(3'd0, 8'h00, 32'h0);
    for (int i = 4; i < 8; i++) rom[i] = mk(3'd0, 8'h00, 32'h0);

    // Reset state
    repeat (2) @(posedge clk); #1;
    check_eq("rst_state", 64'(o_state), 64'd0);
    check_eq("rst_busy", 64'(o_busy), 64'd1);
    check_eq("rst_done", 64'(o_done), 64'd0);
    check_eq("rst_err", 64'(o_err), 64'd0);
    check_eq("rst_strobes", 64'({o_rd, o_wr}), 64'd0);
    check_eq("rst_idx", 64'(o_cmd_idx), 64'd0);

    // Power-up delay: 15 cycles in DELAY, then FETCH
    rst_n = 1'b1; rst2_n = 1'b1;
    repeat (14) @(posedge clk); #1;
    check_eq("delay_hold", 64'(o_state), 64'd0);
    @(posedge clk); #1;
    check_eq("delay_exit", 64'(o_state), 64'd1);

    // Three plain writes then END
    wait_end(200);
    check_eq("s1_count", 64'(log_addr.size() - lb), 64'd3);
    check_log("s1_w0", 0, 1'b1, 8'h02, 32'h0000_0008);
    check_log("s1_w1", 1, 1'b1, 8'h03, 32'hEC36_2200);
    check_log("s1_w2", 2, 1'b1, 8'h04, 32'h0000_0104);
    check_eq("s1_done", 64'(o_done), 64'd1);
    check_eq("s1_busy", 64'(o_busy), 64'd0);
    check_eq("s1_err", 64'(o_err), 64'd0);
    check_eq("s1_state", 64'(o_state), 64'd7);

    // OR with 3 wait-request cycles per phase
    rom[0] = mk(3'd2, 8'h90, 32'h60);
    rom[1] = mk(3'd0, 8'h00, 32'h0);
    wait_n = 3; rd_val = 32'h0011;
    start_seq();
    wait_end(100);
    check_eq("or_rd_cycles", 64'(rd_cycles - rcb), 64'd4);
    check_eq("or_wr_cycles", 64'(wr_cycles - wcb), 64'd4);
    check_eq("or_addr_stable", 64'(addr90_cycles - acb), 64'd8);
    check_log("or_rd", 0, 1'b0, 8'h90, 32'h0000_0011);
    check_log("or_wr", 1, 1'b1, 8'h90, 32'h0000_0071);
    check_eq("or_done", 64'(o_done), 64'd1);

    // ANDN
    rom[0] = mk(3'd3, 8'h02, 32'h3);
    wait_n = 0; rd_val = 32'hF;
    start_seq();
    wait_end(100);
    check_eq("andn_count", 64'(log_addr.size() - lb), 64'd2);
    check_log("andn_wr", 1, 1'b1, 8'h02, 32'hC);

    // POLL_CLR succeeds on the fourth read, then the next command runs
    rom[0] = mk(3'd4, 8'h80, 32'h8000);
    rom[1] = mk(3'd1, 8'h10, 32'h1);
    rom[2] = mk(3'd0, 8'h00, 32'h0);
    rd_first = 32'h8140; rd_val = 32'h0140; rd_switch = 3;
    start_seq();
    wait_end(200);
    check_eq("pclr_count", 64'(log_addr.size() - lb), 64'd5);
    check_log("pclr_r0", 0, 1'b0, 8'h80, 32'h8140);
    check_log("pclr_r3", 3, 1'b0, 8'h80, 32'h0140);
    check_log("pclr_next", 4, 1'b1, 8'h10, 32'h1);
    check_eq("pclr_err", 64'(o_err), 64'd0);
    check_eq("pclr_done", 64'(o_done), 64'd1);

    // POLL_SET timeout at idx 5 after waits
    rom[0] = mk(3'd6, 8'h00, 32'd0);
    rom[1] = mk(3'd6, 8'h00, 32'd3);
    rom[2] = mk(3'd6, 8'h00, 32'd0);
    rom[3] = mk(3'd6, 8'h00, 32'd1);
    rom[4] = mk(3'd6, 8'h00, 32'd2);
    rom[5] = mk(3'd5, 8'h40, 32'h1);
    rom[6] = mk(3'd0, 8'h00, 32'h0);
    rd_val = 32'h0; rd_switch = 0;
    start_seq();
    wait_end(300);
    check_eq("pset_reads", 64'(log_addr.size() - lb), 64'd8);
    check_log("pset_last", 7, 1'b0, 8'h40, 32'h0);
    check_eq("pset_err", 64'(o_err), 64'd1);
    check_eq("pset_err_idx", 64'(o_err_idx), 64'd5);
    check_eq("pset_busy", 64'(o_busy), 64'd0);
    check_eq("pset_done", 64'(o_done), 64'd0);
    check_eq("pset_state", 64'(o_state), 64'd8);
    repeat (20) @(posedge clk); #1;
    check_eq("err_quiet", 64'(log_addr.size() - lb), 64'd8);

    // Restart from ERR skips the power-up delay
    rom[0] = mk(3'd0, 8'h00, 32'h0);
    start_seq();
    check_eq("restart_state", 64'(o_state), 64'd1);
    check_eq("restart_idx", 64'(o_cmd_idx), 64'd0);
    check_eq("restart_err", 64'(o_err), 64'd0);
    check_eq("restart_err_idx", 64'(o_err_idx), 64'd0);
    check_eq("restart_busy", 64'(o_busy), 64'd1);
    wait_end(50);
    check_eq("restart_done", 64'(o_done), 64'd1);

    // Illegal opcode
    rom[0] = mk(3'd1, 8'h11, 32'hA);
    rom[1] = mk(3'd7, 8'h00, 32'h0);
    start_seq();
    wait_end(100);
    check_eq("ill_err", 64'(o_err), 64'd1);
    check_eq("ill_err_idx", 64'(o_err_idx), 64'd1);
    check_eq("ill_count", 64'(log_addr.size() - lb), 64'd1);

    // Reset while a write is held by wait-request
    rom[0] = mk(3'd6, 8'h00, 32'd2);
    rom[1] = mk(3'd1, 8'h20, 32'h5);
    rom[2] = mk(3'd0, 8'h00, 32'h0);
    wait_n = 50;
    start_seq();
    begin
      int n = 0;
      while (!o_wr && n < 30) begin
        @(posedge clk); #1;
        n++;
      end
    end
    check_eq("rst_mid_wr_up", 64'(o_wr), 64'd1);
    check_eq("rst_mid_idx_pre", 64'(o_cmd_idx), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_mid_wr", 64'(o_wr), 64'd0);
    check_eq("rst_mid_state", 64'(o_state), 64'd0);
    check_eq("rst_mid_idx", 64'(o_cmd_idx), 64'd0);
    check_eq("rst_mid_busy", 64'(o_busy), 64'd1);
    rst_n = 1'b1; wait_n = 0;
    wait_end(200);
    check_eq("rst_mid_done", 64'(o_done), 64'd1);
    check_eq("rst_mid_count", 64'(log_addr.size() - lb), 64'd1);
    check_log("rst_mid_w", 0, 1'b1, 8'h20, 32'h5);
    check_eq("both_strobes", 64'(both_hi), 64'd0);

    // Four-entry table with no END finishes at the last index
    check_eq("wrap_done", 64'(done2), 64'd1);
    check_eq("wrap_busy", 64'(busy2), 64'd0);
    check_eq("wrap_err", 64'(err2), 64'd0);
    check_eq("wrap_writes", 64'(wr2_cnt), 64'd4);
    check_eq("wrap_idx", 64'(idx2), 64'd3);
    check_eq("wrap_last_addr", 64'(last2_addr), 64'd3);
    check_eq("wrap_last_data", 64'(last2_data), 64'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
